// File: rtl/asip_ex_pkg.sv
// Shared encodings and flag bundle for the ASIP execute stage.
// EX_STAGE_NV_FLAGS_EN adds the negative/overflow flags to the bundle.
package asip_ex_pkg;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic OPB_REG = 1'b0;
    localparam logic OPB_IMM = 1'b1;

    typedef struct packed {
`ifdef EX_STAGE_NV_FLAGS_EN
        logic n;
        logic v;
`endif
        logic z;
        logic c;
    } ex_flags_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational add/subtract unit producing the result and condition flags.
// N and V are produced only when EX_STAGE_NV_FLAGS_EN is defined.
module ex_alu
    import asip_ex_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             func,
    output logic [WIDTH-1:0] result,
    output ex_flags_t        flags
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Subtract is a + ~b + 1, so carry-out doubles as the "no borrow" flag.
    always_comb begin
        b_eff   = (func == ALU_SUB) ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(func == ALU_SUB);
        result  = sum_ext[WIDTH-1:0];

        flags   = '0;
        flags.z = (sum_ext[WIDTH-1:0] == '0);
        flags.c = sum_ext[WIDTH];
`ifdef EX_STAGE_NV_FLAGS_EN
        flags.n = sum_ext[WIDTH-1];
        // Same rule covers ADD and SUB once b is the effective addend.
        flags.v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
`endif
    end

endmodule

// File: rtl/asip_ex_stage.sv
// Execute stage: operand-B select, add/sub, and the EX/MEM output register.
// Defining EX_STAGE_NV_FLAGS_EN adds registered N and V outputs.
module asip_ex_stage
    import asip_ex_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] rda,
    input  logic [WIDTH-1:0] rdb,
    input  logic [WIDTH-1:0] extended,
    input  logic             alu_func,
    input  logic             opb_selector,
    output logic [WIDTH-1:0] alu_result,
    output logic             Z,
`ifdef EX_STAGE_NV_FLAGS_EN
    output logic             N,
    output logic             V,
`endif
    output logic             C
);

    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_out;
    ex_flags_t        alu_flags;

    logic [WIDTH-1:0] result_d, result_q;
    ex_flags_t        flags_d, flags_q;

    assign opb = (opb_selector == OPB_IMM) ? extended : rdb;

    ex_alu #(
        .WIDTH (WIDTH)
    ) u_ex_alu (
        .a      (rda),
        .b      (opb),
        .func   (alu_func),
        .result (alu_out),
        .flags  (alu_flags)
    );

    // en low is a stall: the EX/MEM register holds.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (en) begin
            result_d = alu_out;
            flags_d  = alu_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign alu_result = result_q;
    assign Z          = flags_q.z;
    assign C          = flags_q.c;
`ifdef EX_STAGE_NV_FLAGS_EN
    assign N          = flags_q.n;
    assign V          = flags_q.v;
`endif

endmodule

// File: tb/tb_asip_ex_stage.sv
// Directed and random bench for asip_ex_stage with an expected-result scoreboard.
module tb_asip_ex_stage;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] rda, rdb, extended;
    logic         alu_func, opb_selector;
    logic [W-1:0] alu_result;
    logic         Z, C;
`ifdef EX_STAGE_NV_FLAGS_EN
    logic         N, V;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         n;
        logic         v;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    asip_ex_stage #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .rda          (rda),
        .rdb          (rdb),
        .extended     (extended),
        .alu_func     (alu_func),
        .opb_selector (opb_selector),
        .alu_result   (alu_result),
        .Z            (Z),
`ifdef EX_STAGE_NV_FLAGS_EN
        .N            (N),
        .V            (V),
`endif
        .C            (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic func);
        exp_t        e;
        logic [W:0]  full;
        if (func == 1'b0) begin
            full  = {1'b0, a} + {1'b0, b};
            e.res = full[W-1:0];
            e.c   = full[W];
            e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        end else begin
            e.res = a - b;
            e.c   = (a >= b);
            e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        e.tag = "";
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check({e.tag, ".result"}, alu_result, e.res);
        check({e.tag, ".Z"}, W'(Z), W'(e.z));
        check({e.tag, ".C"}, W'(C), W'(e.c));
`ifdef EX_STAGE_NV_FLAGS_EN
        check({e.tag, ".N"}, W'(N), W'(e.n));
        check({e.tag, ".V"}, W'(V), W'(e.v));
`endif
    endtask

    // Drive one cycle; use_k forces result/Z/C to the hand-derived constants.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ext,
                        input logic func, input logic sel, input logic en_v, input string tag,
                        input logic use_k, input logic [W-1:0] k_res, input logic k_z,
                        input logic k_c);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rda = a; rdb = b; extended = ext;
        alu_func = func; opb_selector = sel; en = en_v;
        if (en_v) begin
            e = model(a, sel ? ext : b, func);
            if (use_k) begin
                e.res = k_res;
                e.z   = k_z;
                e.c   = k_c;
            end
        end else begin
            e = last_exp;
        end
        e.tag = tag;
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_outputs(got);
    endtask

    initial begin
        exp_t zero_e;
        zero_e = '{res: '0, z: 1'b0, c: 1'b0, n: 1'b0, v: 1'b0, tag: "reset"};
        last_exp = zero_e;

        rst_n = 1'b0; en = 1'b0;
        rda = '0; rdb = '0; extended = '0; alu_func = 1'b0; opb_selector = 1'b0;
        #2;
        check_outputs(zero_e);
        @(negedge clk);
        rst_n = 1'b1;

        step(32'hAA00AA00, 32'h00AA00AA, 32'h0, 1'b0, 1'b0, 1'b1, "add_reg", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
        step(32'hAA00AA01, 32'h0, 32'h00004444, 1'b0, 1'b1, 1'b1, "add_imm", 1'b1, 32'hAA00EE45, 1'b0, 1'b0);
        step(32'hFFFFFFFF, 32'h0, 32'h00000001, 1'b0, 1'b1, 1'b1, "add_wrap", 1'b1, 32'h00000000, 1'b1, 1'b1);
        step(32'hAA00AA00, 32'h00AA00AA, 32'h0, 1'b1, 1'b0, 1'b1, "sub_reg", 1'b1, 32'hA956A956, 1'b0, 1'b1);
        step(32'hAA00AA00, 32'hAA00AA00, 32'h0, 1'b1, 1'b0, 1'b1, "sub_eq", 1'b1, 32'h00000000, 1'b1, 1'b1);
        step(32'h00004444, 32'hAA00AA00, 32'h0, 1'b1, 1'b0, 1'b1, "cmp_borrow", 1'b1, 32'h55FF9A44, 1'b0, 1'b0);
        step(32'h00004444, 32'hAA00AA00, 32'h00004444, 1'b1, 1'b1, 1'b1, "cmp_imm_eq", 1'b1, 32'h00000000, 1'b1, 1'b1);

        // Stall: hold AAAAAAAA through three disabled edges with changing inputs.
        step(32'hAA00AA00, 32'h00AA00AA, 32'h0, 1'b0, 1'b0, 1'b1, "stall_load", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
        step(32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, "stall1", 1'b0, '0, 1'b0, 1'b0);
        step(32'h12345678, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b0, "stall2", 1'b0, '0, 1'b0, 1'b0);
        step(32'h00000000, 32'h00000000, 32'h5, 1'b1, 1'b1, 1'b0, "stall3", 1'b0, '0, 1'b0, 1'b0);
        step(32'h00000001, 32'h00000002, 32'h0, 1'b0, 1'b0, 1'b1, "stall_release", 1'b1, 32'h00000003, 1'b0, 1'b0);

        // Signed-overflow and sign boundaries.
        step(32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b1, "add_ovf", 1'b0, '0, 1'b0, 1'b0);
        step(32'h80000000, 32'h00000001, 32'h0, 1'b1, 1'b0, 1'b1, "sub_ovf", 1'b0, '0, 1'b0, 1'b0);
        step(32'h00000000, 32'h00000001, 32'h0, 1'b1, 1'b0, 1'b1, "sub_neg", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            step($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), $sformatf("rand%0d", i), 1'b0, '0, 1'b0, 1'b0);
        end

        // Async reset mid-cycle while outputs are non-zero.
        step(32'hAA00AA00, 32'h00AA00AA, 32'h0, 1'b0, 1'b0, 1'b1, "pre_reset", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        zero_e.tag = "async_reset";
        check_outputs(zero_e);
        @(posedge clk);
        #1;
        zero_e.tag = "reset_held";
        check_outputs(zero_e);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        zero_e.tag = "post_release_stall";
        check_outputs(zero_e);
        last_exp = zero_e;
        step(32'h00000010, 32'h0, 32'h00000020, 1'b0, 1'b1, 1'b1, "post_reset_add", 1'b1, 32'h00000030, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
